// File: rtl/spi_reg_decoder.sv
// SPI command-frame decoder: turns completed shift-register bytes into
// {cmd, data} frames and writes a bank of 8-bit routing control registers.
module spi_reg_decoder #(
  parameter int NREGS       = 8,
  parameter int AW          = 3,
  parameter int IDLE_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               spi_clk,
  input  logic [7:0]         rx_byte,
  output logic [NREGS*8-1:0] regs_out,
  output logic               wr_strobe,
  output logic [AW-1:0]      wr_addr,
  output logic [7:0]         wr_data,
  output logic               err_addr,
  output logic               err_timeout
);

  localparam int            IW        = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [7:0]    NREGS_W   = 8'(NREGS);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_CMD_HELD = 1'b1;

  logic          sck_s1, sck_s2, sck_d;
  logic          sck_rise, byte_done, timeout_hit, pending, abort;
  logic [2:0]    bit_cnt;
  logic [IW-1:0] idle_cnt;
  logic [0:0]    state;
  logic [7:0]    cmd, byte_q;
  logic          commit_pend;
  logic          addr_ok;
  logic [7:0]    regs [NREGS];

  // spi_clk idles high, so the synchronizer resets high to avoid a false edge
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sck_s1 <= 1'b1;
      sck_s2 <= 1'b1;
      sck_d  <= 1'b1;
    end else begin
      sck_s1 <= spi_clk;
      sck_s2 <= sck_s1;
      sck_d  <= sck_s2;
    end
  end

  assign sck_rise    = sck_s2 & ~sck_d;
  assign byte_done   = sck_rise && (bit_cnt == 3'd7);
  assign pending     = (bit_cnt != 3'd0) || (state == S_CMD_HELD);
  assign timeout_hit = !sck_rise && (idle_cnt == IDLE_LAST);
  assign abort       = timeout_hit && pending;
  assign addr_ok     = ({1'b0, cmd[6:0]} < NREGS_W);

  // Saturating idle counter fires once per quiet stretch; an edge re-arms it
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      idle_cnt    <= '0;
      bit_cnt     <= 3'd0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= abort;
      if (sck_rise) begin
        idle_cnt <= '0;
        bit_cnt  <= bit_cnt + 3'd1;
      end else begin
        if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
        if (abort) bit_cnt <= 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      cmd         <= 8'h00;
      byte_q      <= 8'h00;
      commit_pend <= 1'b0;
    end else begin
      commit_pend <= 1'b0;
      if (byte_done) begin
        byte_q <= rx_byte;
        if (state == S_IDLE) begin
          cmd   <= rx_byte;
          state <= S_CMD_HELD;
        end else begin
          state       <= S_IDLE;
          commit_pend <= 1'b1;
        end
      end else if (abort) begin
        state <= S_IDLE;
      end
    end
  end

  // Commit stage: cmd[7] selects write; out-of-range writes are dropped
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_strobe <= 1'b0;
      err_addr  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      err_addr  <= 1'b0;
      if (commit_pend && cmd[7]) begin
        if (addr_ok) begin
          wr_strobe <= 1'b1;
          wr_addr   <= cmd[AW-1:0];
          wr_data   <= byte_q;
          for (int i = 0; i < NREGS; i++)
            if (cmd[AW-1:0] == AW'(i)) regs[i] <= byte_q;
        end else begin
          err_addr <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
    assign regs_out[8*g +: 8] = regs[g];
  end

endmodule
